// File: rtl/puf_test_ctrl_if.sv
// Bus bundle for puf_test_ctrl: host control/status, PUF response stream,
// test engine bit/result exchange and result memory write port.
//   slave  : the controller's view (drives test_bit*, mem_*, busy/done/error)
//   master : the surrounding system's view (drives control, responses, results)
interface puf_test_ctrl_if #(
  parameter int unsigned RESPONSE_WIDTH = 6,
  parameter int unsigned N_TESTS        = 8,
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH     = 13
);
  localparam int unsigned SEL_WIDTH = (RESPONSE_WIDTH > 1) ? $clog2(RESPONSE_WIDTH) : 1;

  logic                      start;
  logic                      abort;
  logic                      use_xor;
  logic [SEL_WIDTH-1:0]      bit_sel;
  logic [ADDR_WIDTH-1:0]     base_addr;
  logic                      resp_valid;
  logic [RESPONSE_WIDTH-1:0] raw_response;
  logic                      test_bit;
  logic                      test_bit_valid;
  logic [N_TESTS-1:0]        test_result;
  logic                      test_result_valid;
  logic                      mem_we;
  logic [ADDR_WIDTH-1:0]     mem_waddr;
  logic [COUNT_WIDTH-1:0]    mem_din;
  logic                      busy;
  logic                      done;
  logic                      error;

  modport slave (
    input  start, abort, use_xor, bit_sel, base_addr, resp_valid, raw_response,
           test_result, test_result_valid,
    output test_bit, test_bit_valid, mem_we, mem_waddr, mem_din, busy, done, error
  );

  modport master (
    output start, abort, use_xor, bit_sel, base_addr, resp_valid, raw_response,
           test_result, test_result_valid,
    input  test_bit, test_bit_valid, mem_we, mem_waddr, mem_din, busy, done, error
  );
endinterface

// File: rtl/puf_test_ctrl.sv
// On-chip statistical test controller for the PUF core.
// Streams one selected response bit (or the XOR of the response) per valid
// PUF response to the randomness test engine, accumulates saturating per-test
// pass counts over N_ROUNDS rounds, then writes the counts and a summary word
// {error, rounds} to result memory starting at base_addr.
// Ports: clk, rst (async, active-high), bus (puf_test_ctrl_if.slave) carrying
// start/abort/use_xor/bit_sel/base_addr, resp_valid/raw_response,
// test_bit/test_bit_valid, test_result/test_result_valid,
// mem_we/mem_waddr/mem_din and busy/done/error.
module puf_test_ctrl #(
  parameter int unsigned RESPONSE_WIDTH = 6,
  parameter int unsigned N_TESTS        = 8,
  parameter int unsigned BITS_PER_ROUND = 20000,
  parameter int unsigned N_ROUNDS       = 255,
  parameter int unsigned COUNT_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned RESULT_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  puf_test_ctrl_if.slave   bus
);
  localparam int unsigned SEL_WIDTH     = (RESPONSE_WIDTH > 1) ? $clog2(RESPONSE_WIDTH) : 1;
  localparam int unsigned BIT_CNT_WIDTH = $clog2(BITS_PER_ROUND + 1);
  localparam int unsigned TO_WIDTH      = $clog2(RESULT_TIMEOUT + 1);
  localparam int unsigned IDX_WIDTH     = $clog2(N_TESTS + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COLLECT, S_WAIT_RES, S_ACCUM, S_DUMP, S_DONE
  } state_t;

  state_t                   state;
  logic [BIT_CNT_WIDTH-1:0] bit_cnt;
  logic [TO_WIDTH-1:0]      to_cnt;
  logic [COUNT_WIDTH-1:0]   rounds;
  logic [N_TESTS-1:0]       res_q;
  logic [IDX_WIDTH-1:0]     dump_idx;
  logic [COUNT_WIDTH-1:0]   pass_cnt [N_TESTS];

  logic                     test_bit_q;
  logic                     test_bit_valid_q;
  logic                     mem_we_q;
  logic [ADDR_WIDTH-1:0]    mem_waddr_q;
  logic [COUNT_WIDTH-1:0]   mem_din_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     error_q;

  logic                     sel_bit_c;
  logic [COUNT_WIDTH-1:0]   cnt_sat_c [N_TESTS];
  logic [COUNT_WIDTH-1:0]   dump_word_c;

  // Bit selection; out-of-range bit_sel falls back to bit 0.
  always_comb begin
    sel_bit_c = bus.raw_response[0];
    for (int i = 0; i < int'(RESPONSE_WIDTH); i++) begin
      if (bus.bit_sel == SEL_WIDTH'(i)) sel_bit_c = bus.raw_response[i];
    end
    if (bus.use_xor) sel_bit_c = ^bus.raw_response;
  end

  // Saturating increment of each pass counter by the latched round result.
  always_comb begin
    for (int i = 0; i < int'(N_TESTS); i++) begin
      cnt_sat_c[i] = (res_q[i] && (pass_cnt[i] != '1)) ?
                     pass_cnt[i] + COUNT_WIDTH'(1) : pass_cnt[i];
    end
  end

  // Word for the current dump slot: a counter, or the trailing summary word.
  always_comb begin
    dump_word_c = {error_q, rounds[COUNT_WIDTH-2:0]};
    for (int i = 0; i < int'(N_TESTS); i++) begin
      if (dump_idx == IDX_WIDTH'(i)) dump_word_c = pass_cnt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      bit_cnt          <= '0;
      to_cnt           <= '0;
      rounds           <= '0;
      res_q            <= '0;
      dump_idx         <= '0;
      for (int i = 0; i < int'(N_TESTS); i++) pass_cnt[i] <= '0;
      test_bit_q       <= 1'b0;
      test_bit_valid_q <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_waddr_q      <= '0;
      mem_din_q        <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      test_bit_valid_q <= 1'b0;
      if (bus.abort) begin
        // Counters are kept; only status and the write strobe are dropped.
        state    <= S_IDLE;
        mem_we_q <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        error_q  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              state  <= S_CLEAR;
              busy_q <= 1'b1;
            end
          end
          S_CLEAR: begin
            for (int i = 0; i < int'(N_TESTS); i++) pass_cnt[i] <= '0;
            bit_cnt <= '0;
            rounds  <= '0;
            error_q <= 1'b0;
            state   <= S_COLLECT;
          end
          S_COLLECT: begin
            if (bus.resp_valid) begin
              test_bit_q       <= sel_bit_c;
              test_bit_valid_q <= 1'b1;
              bit_cnt          <= bit_cnt + BIT_CNT_WIDTH'(1);
              if (bit_cnt == BIT_CNT_WIDTH'(BITS_PER_ROUND - 1)) begin
                to_cnt <= '0;
                state  <= S_WAIT_RES;
              end
            end
          end
          S_WAIT_RES: begin
            if (bus.test_result_valid) begin
              res_q <= bus.test_result;
              state <= S_ACCUM;
            end else if (to_cnt == TO_WIDTH'(RESULT_TIMEOUT - 1)) begin
              res_q   <= '0;
              error_q <= 1'b1;
              state   <= S_ACCUM;
            end else begin
              to_cnt <= to_cnt + TO_WIDTH'(1);
            end
          end
          S_ACCUM: begin
            for (int i = 0; i < int'(N_TESTS); i++) pass_cnt[i] <= cnt_sat_c[i];
            rounds  <= rounds + COUNT_WIDTH'(1);
            bit_cnt <= '0;
            if (rounds == COUNT_WIDTH'(N_ROUNDS - 1)) begin
              // Issue the first write here so mem_we spans exactly the DUMP cycles.
              mem_we_q    <= 1'b1;
              mem_waddr_q <= bus.base_addr;
              mem_din_q   <= cnt_sat_c[0];
              dump_idx    <= IDX_WIDTH'(1);
              state       <= S_DUMP;
            end else begin
              state <= S_COLLECT;
            end
          end
          S_DUMP: begin
            if (dump_idx <= IDX_WIDTH'(N_TESTS)) begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= bus.base_addr + ADDR_WIDTH'(dump_idx);
              mem_din_q   <= dump_word_c;
              dump_idx    <= dump_idx + IDX_WIDTH'(1);
            end else begin
              mem_we_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state    <= S_DONE;
            end
          end
          S_DONE: begin
            if (bus.start) begin
              state  <= S_CLEAR;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.test_bit       = test_bit_q;
  assign bus.test_bit_valid = test_bit_valid_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_waddr      = mem_waddr_q;
  assign bus.mem_din        = mem_din_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
endmodule

// File: tb/tb_puf_test_ctrl.sv
// Self-checking bench for puf_test_ctrl: a 3-round/16-bit/4-test instance for
// selection, run, timeout, abort, address wrap and reset cases, and a
// 255-round instance for the full-count case.
module tb_puf_test_ctrl;
  localparam int unsigned RW = 6, NT = 4, CW = 8, AW = 13, TO = 20;
  localparam int unsigned BPR_A = 16, NR_A = 3;
  localparam int unsigned BPR_B = 2,  NR_B = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  puf_test_ctrl_if #(.RESPONSE_WIDTH(RW), .N_TESTS(NT), .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) ifa ();
  puf_test_ctrl_if #(.RESPONSE_WIDTH(RW), .N_TESTS(NT), .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) ifb ();

  puf_test_ctrl #(.RESPONSE_WIDTH(RW), .N_TESTS(NT), .BITS_PER_ROUND(BPR_A), .N_ROUNDS(NR_A),
                  .COUNT_WIDTH(CW), .ADDR_WIDTH(AW), .RESULT_TIMEOUT(TO))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));

  puf_test_ctrl #(.RESPONSE_WIDTH(RW), .N_TESTS(NT), .BITS_PER_ROUND(BPR_B), .N_ROUNDS(NR_B),
                  .COUNT_WIDTH(CW), .ADDR_WIDTH(AW), .RESULT_TIMEOUT(TO))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int checks;
  int failures;
  int run_id;

  // Stimulus controls owned by the main process.
  logic       man_rv;
  int         gen_mode;   // 0 off, 1 every cycle, 2 one pulse every 6 cycles
  logic [3:0] pat_a;
  logic [2:0] skip_a;     // rounds whose result is withheld

  // Owned by the generator.
  logic gen_rv;
  int   gen_ph;
  assign ifa.resp_valid = man_rv | gen_rv;

  // Owned by the monitor.
  int tbv_cnt, ones_cnt, cyc, done_cyc, mon_run;
  logic done_prev;
  int wa[$];
  int wd[$];
  int wc[$];

  typedef struct {
    logic       use_xor;
    logic [2:0] bit_sel;
    logic [5:0] raw;
    logic       exp_bit;
  } sel_vec_t;
  sel_vec_t vecs [11];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_test_bit"}, ifa.test_bit, 0);
    check({tag, "_test_bit_valid"}, ifa.test_bit_valid, 0);
    check({tag, "_mem_we"}, ifa.mem_we, 0);
    check({tag, "_mem_waddr"}, ifa.mem_waddr, 0);
    check({tag, "_mem_din"}, ifa.mem_din, 0);
    check({tag, "_busy"}, ifa.busy, 0);
    check({tag, "_done"}, ifa.done, 0);
    check({tag, "_error"}, ifa.error, 0);
  endtask

  task automatic start_a();
    @(negedge clk);
    run_id++;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    check("start_busy", ifa.busy, 1);
    check("start_done_low", ifa.done, 0);
  endtask

  task automatic wait_done_a(input int budget);
    int n;
    n = 0;
    while (!ifa.done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", ifa.done, 1);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input int ea [5], input int ed [5]);
    check({tag, "_nwrites"}, wa.size(), 5);
    if (wa.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("%s_addr%0d", tag, i), wa[i], ea[i]);
        check($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
      end
      check({tag, "_we_consecutive"}, wc[4] - wc[0], 4);
      check({tag, "_done_after_last"}, done_cyc, wc[4] + 1);
    end
  endtask

  // Response generator.
  initial begin
    gen_rv = 1'b0;
    gen_ph = 0;
    forever begin
      @(negedge clk);
      gen_ph = (gen_ph == 5) ? 0 : gen_ph + 1;
      gen_rv = (gen_mode == 1) || (gen_mode == 2 && gen_ph == 0);
    end
  end

  // Test engine model for dut_a: one result strobe per BPR_A bits.
  initial begin
    int bc, rnd, last;
    bc = 0; rnd = 0; last = 0;
    ifa.test_result_valid = 1'b0;
    ifa.test_result = '0;
    forever begin
      @(negedge clk);
      if (run_id != last) begin
        last = run_id; bc = 0; rnd = 0;
      end
      ifa.test_result_valid = 1'b0;
      if (ifa.test_bit_valid === 1'b1) begin
        bc++;
        if (bc == int'(BPR_A)) begin
          bc = 0;
          if (!(rnd < 3 && skip_a[rnd])) begin
            ifa.test_result_valid = 1'b1;
            ifa.test_result = pat_a;
          end
          rnd++;
        end
      end
    end
  end

  // Test engine model for dut_b: always all-pass.
  initial begin
    int bc;
    bc = 0;
    ifb.test_result_valid = 1'b0;
    ifb.test_result = 4'hF;
    forever begin
      @(negedge clk);
      ifb.test_result_valid = 1'b0;
      if (ifb.test_bit_valid === 1'b1) begin
        bc++;
        if (bc == int'(BPR_B)) begin
          bc = 0;
          ifb.test_result_valid = 1'b1;
        end
      end
    end
  end

  // Monitor for dut_a: bit stream stats and memory writes per run.
  initial begin
    cyc = 0; mon_run = 0; tbv_cnt = 0; ones_cnt = 0; done_cyc = -1; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (run_id != mon_run) begin
        mon_run = run_id;
        tbv_cnt = 0; ones_cnt = 0; done_cyc = -1;
        wa.delete(); wd.delete(); wc.delete();
      end
      if (ifa.test_bit_valid === 1'b1) begin
        tbv_cnt++;
        if (ifa.test_bit === 1'b1) ones_cnt++;
      end
      if (ifa.mem_we === 1'b1) begin
        wa.push_back(int'(ifa.mem_waddr));
        wd.push_back(int'(ifa.mem_din));
        wc.push_back(cyc);
      end
      if (ifa.done === 1'b1 && !done_prev) done_cyc = cyc;
      done_prev = (ifa.done === 1'b1);
    end
  end

  initial begin
    int seen, n, nb;
    int bwd [5];
    checks = 0; failures = 0; run_id = 0;
    man_rv = 1'b0; gen_mode = 0; pat_a = 4'b0; skip_a = 3'b0;

    vecs[0]  = '{1'b0, 3'd2, 6'b000100, 1'b1};
    vecs[1]  = '{1'b0, 3'd2, 6'b111011, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 6'b000001, 1'b1};
    vecs[3]  = '{1'b0, 3'd5, 6'b100000, 1'b1};
    vecs[4]  = '{1'b0, 3'd5, 6'b011111, 1'b0};
    vecs[5]  = '{1'b0, 3'd6, 6'b000001, 1'b1};
    vecs[6]  = '{1'b0, 3'd7, 6'b111110, 1'b0};
    vecs[7]  = '{1'b0, 3'd3, 6'b001000, 1'b1};
    vecs[8]  = '{1'b1, 3'd0, 6'b000111, 1'b1};
    vecs[9]  = '{1'b1, 3'd0, 6'b000011, 1'b0};
    vecs[10] = '{1'b1, 3'd4, 6'b100000, 1'b1};

    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.use_xor = 1'b0; ifa.bit_sel = 3'd2;
    ifa.base_addr = 13'd100; ifa.raw_response = 6'b000100;
    ifb.start = 1'b0; ifb.abort = 1'b0; ifb.use_xor = 1'b0; ifb.bit_sel = 3'd0;
    ifb.base_addr = 13'd0; ifb.raw_response = 6'b111111; ifb.resp_valid = 1'b0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    rst = 1'b0;

    // Bit selection table, then abort mid-COLLECT.
    start_a();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ifa.use_xor = vecs[i].use_xor;
      ifa.bit_sel = vecs[i].bit_sel;
      ifa.raw_response = vecs[i].raw;
      man_rv = 1'b1;
      @(negedge clk);
      man_rv = 1'b0;
      check($sformatf("sel%0d_valid", i), ifa.test_bit_valid, 1);
      check($sformatf("sel%0d_bit", i), ifa.test_bit, vecs[i].exp_bit);
    end
    @(negedge clk);
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.abort = 1'b0;
    check("abort_collect_busy", ifa.busy, 0);
    check("abort_collect_done", ifa.done, 0);
    check("abort_collect_we", ifa.mem_we, 0);
    man_rv = 1'b1;
    @(negedge clk);
    man_rv = 1'b0;
    @(negedge clk);
    check("idle_resp_ignored", ifa.test_bit_valid, 0);

    // Nominal run: bit 2 of 000100, engine returns 1011 each round.
    ifa.use_xor = 1'b0; ifa.bit_sel = 3'd2; ifa.raw_response = 6'b000100;
    pat_a = 4'b1011; skip_a = 3'b000; ifa.base_addr = 13'd100; gen_mode = 1;
    start_a();
    wait_done_a(1000);
    check("run1_bits", tbv_cnt, 48);
    check("run1_ones", ones_cnt, 48);
    check("run1_error", ifa.error, 0);
    check("run1_busy", ifa.busy, 0);
    check_writes("run1", '{100, 101, 102, 103, 104}, '{3, 3, 0, 3, 3});

    // Restart from DONE: XOR mode, sparse responses, engine returns 0101.
    ifa.use_xor = 1'b1; ifa.raw_response = 6'b000011; pat_a = 4'b0101; gen_mode = 2;
    start_a();
    wait_done_a(2000);
    check("run2_bits", tbv_cnt, 48);
    check("run2_ones", ones_cnt, 0);
    check_writes("run2", '{100, 101, 102, 103, 104}, '{3, 0, 3, 0, 3});

    // Round 1 result withheld: timeout counts it as all-fail.
    ifa.use_xor = 1'b0; ifa.raw_response = 6'b000100; pat_a = 4'b1111; skip_a = 3'b010;
    gen_mode = 1;
    start_a();
    wait_done_a(1000);
    check("run3_error", ifa.error, 1);
    check_writes("run3", '{100, 101, 102, 103, 104}, '{2, 2, 2, 2, 131});

    // Abort after two DUMP writes; round 0 timed out so error is set first.
    skip_a = 3'b001;
    start_a();
    seen = 0; n = 0;
    while (seen < 2 && n < 1000) begin
      @(negedge clk);
      n++;
      if (ifa.mem_we === 1'b1) seen++;
    end
    check("run4_dump_reached", seen, 2);
    check("run4_error_before_abort", ifa.error, 1);
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.abort = 1'b0;
    check("abort_dump_we", ifa.mem_we, 0);
    check("abort_dump_busy", ifa.busy, 0);
    check("abort_dump_done", ifa.done, 0);
    check("abort_dump_error", ifa.error, 0);
    @(negedge clk);
    check("abort_dump_nwrites", wa.size(), 2);

    // Clean run after abort, addresses wrapping past 2^13-1.
    skip_a = 3'b000; pat_a = 4'b1011; ifa.base_addr = 13'd8190;
    start_a();
    wait_done_a(1000);
    check_writes("wrap", '{8190, 8191, 0, 1, 2}, '{3, 3, 0, 3, 3});

    // Asynchronous reset mid-COLLECT.
    start_a();
    repeat (4) @(negedge clk);
    check("pre_rst_valid", ifa.test_bit_valid, 1);
    check("pre_rst_bit", ifa.test_bit, 1);
    #2 rst = 1'b1;
    #1 check_reset_a("async_rst");
    @(negedge clk);
    rst = 1'b0;
    gen_mode = 0;

    // 255 all-pass rounds reach the counter maximum without wrapping.
    @(negedge clk);
    ifb.resp_valid = 1'b1;
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    nb = 0; n = 0;
    while (!ifb.done && n < 5000) begin
      @(negedge clk);
      n++;
      if (ifb.mem_we === 1'b1) begin
        if (nb < 5) bwd[nb] = int'(ifb.mem_din);
        nb++;
      end
    end
    check("full_done", ifb.done, 1);
    check("full_nwrites", nb, 5);
    if (nb == 5) begin
      for (int i = 0; i < 4; i++) check($sformatf("full_cnt%0d", i), bwd[i], 255);
      check("full_summary", bwd[4], 127);
    end
    check("full_error", ifb.error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
